// File: rtl/risc8_pkg.sv
// Shared risc8 types: stack command opcodes and the stack engine FSM states.
package risc8_pkg;

  typedef enum logic [1:0] {
    OP_PUSH = 2'd0,
    OP_POP  = 2'd1,
    OP_CALL = 2'd2,
    OP_RET  = 2'd3
  } stack_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    RESP = 2'd3
  } stack_state_e;

  function automatic logic is_push_op(input stack_op_e op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

  function automatic logic is_multi_op(input stack_op_e op);
    return (op == OP_CALL) || (op == OP_RET);
  endfunction

endpackage

// File: rtl/stack_beat_ctr.sv
// Loadable down-counter with zero flag; sequences the beats of multi-byte transfers.
module stack_beat_ctr
  import risc8_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Beat count register: load wins over decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign zero  = (count_r == {W{1'b0}});

endmodule

// File: rtl/stack_engine.sv
// Stack controller: owns SP/depth and sequences PUSH/POP/CALL/RET as byte beats.
// Optional overflow/underflow refusal when STACK_GUARD_EN is defined.
module stack_engine
  import risc8_pkg::*;
#(
  parameter int                     WORD    = 8,
  parameter int                     PC_W    = 16,
  parameter int                     SP_W    = 16,
  parameter int                     ADDR_W  = 24,
  parameter logic [ADDR_W-SP_W-1:0] BASE    = 8'hFF,
  parameter logic [SP_W-1:0]        SP_INIT = {SP_W{1'b1}},
  parameter int                     DEPTH   = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  stack_op_e                    cmd_op,
  input  logic [PC_W-1:0]              cmd_data,
  output logic                         rsp_valid,
  output logic [PC_W-1:0]              rsp_data,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [WORD-1:0]              mem_wdata,
  input  logic [WORD-1:0]              mem_rdata,
  input  logic                         mem_ack,
  output logic [SP_W-1:0]              sp,
  output logic [$clog2(DEPTH+1)-1:0]   depth,
  output logic                         fault
);

  localparam int              PC_BYTES  = PC_W / WORD;
  localparam int              DW        = $clog2(DEPTH + 1);
  localparam int              CW        = $clog2(PC_BYTES + 1);
  localparam logic [DW-1:0]   DEPTH_MAX = DW'(DEPTH);

  stack_state_e      state_r;
  logic [SP_W-1:0]   sp_r;
  logic [DW-1:0]     depth_r;
  logic [PC_W-1:0]   data_r;
  logic [CW-1:0]     beats_r;
  logic              cmd_ready_r;
  logic              rsp_valid_r;
  logic [PC_W-1:0]   rsp_data_r;
  logic              mem_req_r;
  logic              mem_we_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [WORD-1:0]   mem_wdata_r;
  logic              fault_r;

  logic              accept_s;
  logic              push_type_s;
  logic [CW-1:0]     beats_s;
  logic              refuse_s;
  logic              ack_s;
  logic [CW-1:0]     cnt_s;
  logic              cnt_zero_s;
  logic [CW-1:0]     rd_slot_s;
  logic [PC_W-1:0]   assembled_s;

  function automatic logic [WORD-1:0] sel_byte(input logic [PC_W-1:0] d, input logic [CW-1:0] idx);
    logic [WORD-1:0] b;
    b = {WORD{1'b0}};
    for (int i = 0; i < PC_BYTES; i++) begin
      if (CW'(i) == idx) begin
        b = d[i*WORD +: WORD];
      end
    end
    return b;
  endfunction

  assign accept_s    = cmd_valid && cmd_ready_r;
  assign push_type_s = is_push_op(cmd_op);
  assign beats_s     = is_multi_op(cmd_op) ? CW'(PC_BYTES) : CW'(1);
  // Acks are only meaningful while a beat is outstanding; orphan acks fall through.
  assign ack_s       = mem_ack && mem_req_r;
  // Reads fill low byte first while the counter runs down.
  assign rd_slot_s   = beats_r - CW'(1) - cnt_s;

  // Admission check against the configured stack capacity.
  always_comb begin
    refuse_s = 1'b0;
`ifdef STACK_GUARD_EN
    if (push_type_s) begin
      refuse_s = (int'(depth_r) + int'(beats_s)) > DEPTH;
    end else begin
      refuse_s = int'(depth_r) < int'(beats_s);
    end
`endif
  end

  // Popped value with the byte arriving this cycle merged into its slot.
  always_comb begin
    assembled_s = data_r;
    for (int i = 0; i < PC_BYTES; i++) begin
      if (CW'(i) == rd_slot_s) begin
        assembled_s[i*WORD +: WORD] = mem_rdata;
      end else begin
        assembled_s[i*WORD +: WORD] = data_r[i*WORD +: WORD];
      end
    end
  end

  stack_beat_ctr #(.W(CW)) u_beat_ctr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s),
    .load_val (beats_s - CW'(1)),
    .dec      (ack_s && !cnt_zero_s),
    .count    (cnt_s),
    .zero     (cnt_zero_s)
  );

  // Command FSM with SP/depth bookkeeping and registered memory/response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sp_r        <= SP_INIT;
      depth_r     <= {DW{1'b0}};
      data_r      <= {PC_W{1'b0}};
      beats_r     <= {CW{1'b0}};
      cmd_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {PC_W{1'b0}};
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {WORD{1'b0}};
      fault_r     <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      fault_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            cmd_ready_r <= 1'b0;
            beats_r     <= beats_s;
            if (refuse_s) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= {PC_W{1'b0}};
              fault_r     <= 1'b1;
            end else if (push_type_s) begin
              state_r     <= WR;
              data_r      <= cmd_data;
              mem_req_r   <= 1'b1;
              mem_we_r    <= 1'b1;
              mem_addr_r  <= {BASE, sp_r};
              mem_wdata_r <= sel_byte(cmd_data, beats_s - CW'(1));
            end else begin
              state_r     <= RD;
              data_r      <= {PC_W{1'b0}};
              sp_r        <= sp_r + SP_W'(1);
              mem_req_r   <= 1'b1;
              mem_we_r    <= 1'b0;
              mem_addr_r  <= {BASE, sp_r + SP_W'(1)};
            end
          end
        end
        WR: begin
          if (ack_s) begin
            sp_r <= sp_r - SP_W'(1);
            if (depth_r != DEPTH_MAX) begin
              depth_r <= depth_r + DW'(1);
            end
            if (cnt_zero_s) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= {PC_W{1'b0}};
              mem_req_r   <= 1'b0;
              mem_we_r    <= 1'b0;
              mem_addr_r  <= {ADDR_W{1'b0}};
              mem_wdata_r <= {WORD{1'b0}};
            end else begin
              mem_addr_r  <= {BASE, sp_r - SP_W'(1)};
              mem_wdata_r <= sel_byte(data_r, cnt_s - CW'(1));
            end
          end
        end
        RD: begin
          if (ack_s) begin
            data_r <= assembled_s;
            if (depth_r != {DW{1'b0}}) begin
              depth_r <= depth_r - DW'(1);
            end
            if (cnt_zero_s) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= assembled_s;
              mem_req_r   <= 1'b0;
              mem_addr_r  <= {ADDR_W{1'b0}};
            end else begin
              sp_r       <= sp_r + SP_W'(1);
              mem_addr_r <= {BASE, sp_r + SP_W'(1)};
            end
          end
        end
        RESP: begin
          state_r     <= IDLE;
          cmd_ready_r <= 1'b1;
          rsp_data_r  <= {PC_W{1'b0}};
        end
        default: begin
          state_r     <= IDLE;
          cmd_ready_r <= 1'b1;
          mem_req_r   <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_data  = rsp_data_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign sp        = sp_r;
  assign depth     = depth_r;
  assign fault     = fault_r;

endmodule

// File: tb/tb_stack_engine.sv
// Bench for stack_engine: transaction-level stack model, memory responder with
// programmable ack delay, and directed command sequences.
module tb_stack_engine;
  import risc8_pkg::*;

`ifdef STACK_GUARD_EN
  localparam int TB_DEPTH = 2;
`else
  localparam int TB_DEPTH = 256;
`endif
  localparam logic [7:0] TB_BASE = 8'hFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  stack_op_e   cmd_op;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;
  logic [15:0] sp;
  logic [8:0]  depth;
  logic        fault;

  always #5 clk = ~clk;

  stack_engine #(.DEPTH(TB_DEPTH)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .sp(sp), .depth(depth), .fault(fault)
  );

  typedef struct { bit we; logic [23:0] addr; logic [7:0] data; } beat_t;
  typedef struct { logic [15:0] data; logic [15:0] sp; int depth; bit fault; int lat; } rsp_t;

  int n_checks = 0;
  int n_errors = 0;
  int ack_wait = 0;

  beat_t      exp_beats[$];
  rsp_t       exp_rsp[$];
  bit [15:0]  m_sp = 16'hFFFF;
  int         m_depth = 0;
  bit [7:0]   m_mem [int];
  bit [7:0]   r_mem [int];

  logic [23:0] last_addr;
  logic [7:0]  last_wdata;
  logic [15:0] last_rsp;
  int          last_lat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s at time %0t", name, $time);
  endtask

  // Predict beats and response of one command from stack semantics.
  task automatic model_cmd(input stack_op_e op, input logic [15:0] data, input int wt);
    int    nb;
    bit    push;
    bit    refuse;
    beat_t b;
    rsp_t  r;
    logic [15:0] val;
    nb = (op == OP_CALL || op == OP_RET) ? 2 : 1;
    push = (op == OP_PUSH || op == OP_CALL);
    refuse = 1'b0;
`ifdef STACK_GUARD_EN
    refuse = push ? (m_depth + nb > TB_DEPTH) : (m_depth < nb);
`endif
    r.fault = refuse;
    r.data = 16'h0000;
    if (refuse) begin
      r.lat = 2;
    end else begin
      r.lat = 2 + nb * (wt + 1);
      if (push) begin
        for (int k = nb - 1; k >= 0; k--) begin
          b.we = 1'b1;
          b.addr = {TB_BASE, m_sp};
          b.data = data[k*8 +: 8];
          exp_beats.push_back(b);
          m_mem[int'(b.addr)] = b.data;
          m_sp = m_sp - 16'd1;
          if (m_depth < TB_DEPTH) m_depth++;
        end
      end else begin
        val = 16'h0000;
        for (int k = 0; k < nb; k++) begin
          m_sp = m_sp + 16'd1;
          b.we = 1'b0;
          b.addr = {TB_BASE, m_sp};
          b.data = 8'h00;
          exp_beats.push_back(b);
          val[k*8 +: 8] = m_mem.exists(int'(b.addr)) ? m_mem[int'(b.addr)] : 8'h00;
          if (m_depth > 0) m_depth--;
        end
        r.data = val;
      end
    end
    r.sp = m_sp;
    r.depth = m_depth;
    exp_rsp.push_back(r);
  endtask

  // Memory responder: acks each beat after ack_wait idle cycles.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (mem_req && !rst && wcnt >= ack_wait) begin
        mem_ack = 1'b1;
        mem_rdata = r_mem.exists(int'(mem_addr)) ? r_mem[int'(mem_addr)] : 8'h00;
        if (mem_we) r_mem[int'(mem_addr)] = mem_wdata;
        wcnt = 0;
      end else if (mem_req && !rst) begin
        mem_ack = 1'b0;
        wcnt++;
      end else begin
        mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Compare process: beats, beat stability, responses and latency.
  initial begin
    bit          in_beat;
    bit          fault_seen;
    int          lat;
    logic [23:0] h_addr;
    logic [7:0]  h_wdata;
    logic        h_we;
    beat_t       b;
    rsp_t        r;
    in_beat = 1'b0;
    fault_seen = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_beat = 1'b0;
        lat = 0;
      end else begin
        if (lat > 0) lat++;
        if (cmd_valid && cmd_ready) begin
          lat = 1;
          fault_seen = 1'b0;
        end
        if (fault) fault_seen = 1'b1;
`ifndef STACK_GUARD_EN
        check("fault_tied_low", fault, 1'b0);
`endif
        if (mem_req) begin
          if (in_beat) begin
            check("hold_addr", mem_addr, h_addr);
            check("hold_we", mem_we, h_we);
            check("hold_wdata", mem_wdata, h_wdata);
          end else begin
            h_addr = mem_addr;
            h_we = mem_we;
            h_wdata = mem_wdata;
          end
          if (mem_ack) begin
            in_beat = 1'b0;
            if (exp_beats.size() == 0) begin
              fail("unexpected_beat");
            end else begin
              b = exp_beats.pop_front();
              check("beat_we", mem_we, b.we);
              check("beat_addr", mem_addr, b.addr);
              if (b.we) check("beat_wdata", mem_wdata, b.data);
              last_addr = mem_addr;
              last_wdata = mem_wdata;
            end
          end else begin
            in_beat = 1'b1;
          end
        end
        if (rsp_valid) begin
          if (exp_rsp.size() == 0) begin
            fail("unexpected_rsp");
          end else begin
            r = exp_rsp.pop_front();
            check("rsp_data", rsp_data, r.data);
            check("rsp_sp", sp, r.sp);
            check("rsp_depth", depth, r.depth);
            check("rsp_fault", fault_seen, r.fault);
            check("rsp_latency", lat, r.lat);
            last_rsp = rsp_data;
            last_lat = lat;
          end
          lat = 0;
        end
      end
    end
  end

  task automatic run_cmd(input stack_op_e op, input logic [15:0] data, input int wt);
    bit got;
    ack_wait = wt;
    model_cmd(op, data, wt);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = OP_RET;
    cmd_data = 16'hDEAD;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) fail("rsp_timeout");
    @(posedge clk); #1;
    check("beats_drained", exp_beats.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = OP_PUSH;
    cmd_data = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sp", sp, 16'hFFFF);
    check("rst_depth", depth, 0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_data", rsp_data, 16'h0000);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 24'h000000);
    check("rst_mem_wdata", mem_wdata, 8'h00);
    check("rst_fault", fault, 1'b0);
    rst = 1'b0;

    run_cmd(OP_PUSH, 16'h00A5, 0);
    check("push_addr", last_addr, 24'hFFFFFF);
    check("push_wdata", last_wdata, 8'hA5);
    check("push_sp", sp, 16'hFFFE);
    check("push_depth", depth, 1);
    check("push_latency", last_lat, 3);

    run_cmd(OP_POP, 16'h0000, 0);
    check("pop_addr", last_addr, 24'hFFFFFF);
    check("pop_data", last_rsp, 16'h00A5);
    check("pop_sp", sp, 16'hFFFF);
    check("pop_depth", depth, 0);

    run_cmd(OP_CALL, 16'h1234, 0);
    check("call_low_addr", last_addr, 24'hFFFFFE);
    check("call_low_byte", last_wdata, 8'h34);
    check("call_latency", last_lat, 4);
    run_cmd(OP_RET, 16'h0000, 0);
    check("ret_last_addr", last_addr, 24'hFFFFFF);
    check("ret_data", last_rsp, 16'h1234);
    check("ret_sp", sp, 16'hFFFF);

    run_cmd(OP_CALL, 16'hABCD, 3);
    check("slow_call_latency", last_lat, 10);
    run_cmd(OP_RET, 16'h0000, 1);
    check("slow_ret_data", last_rsp, 16'hABCD);

    run_cmd(OP_POP, 16'h0000, 0);
`ifndef STACK_GUARD_EN
    check("underflow_sp_wrap", sp, 16'h0000);
    check("underflow_depth", depth, 0);
    check("underflow_addr", last_addr, 24'hFF0000);
`endif
    run_cmd(OP_PUSH, 16'h005A, 2);
`ifndef STACK_GUARD_EN
    check("wrap_push_addr", last_addr, 24'hFF0000);
    check("wrap_push_sp", sp, 16'hFFFF);
`endif

    run_cmd(OP_PUSH, 16'h0011, 1);
    run_cmd(OP_PUSH, 16'h0022, 0);
    run_cmd(OP_CALL, 16'hBEEF, 2);
    run_cmd(OP_RET, 16'h0000, 0);
    run_cmd(OP_POP, 16'h0000, 1);
    run_cmd(OP_POP, 16'h0000, 0);

    // Reset while the second CALL beat is outstanding.
    ack_wait = 0;
    model_cmd(OP_CALL, 16'h5555, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op = OP_CALL;
    cmd_data = 16'h5555;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("midop_req_before_rst", mem_req, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midop_sp", sp, 16'hFFFF);
    check("midop_depth", depth, 0);
    check("midop_mem_req", mem_req, 1'b0);
    check("midop_cmd_ready", cmd_ready, 1'b1);
    check("midop_rsp_valid", rsp_valid, 1'b0);
    exp_beats.delete();
    exp_rsp.delete();
    m_sp = 16'hFFFF;
    m_depth = 0;
    repeat (4) @(posedge clk);
    #1;

`ifdef STACK_GUARD_EN
    run_cmd(OP_PUSH, 16'h0001, 0);
    run_cmd(OP_PUSH, 16'h0002, 0);
    run_cmd(OP_PUSH, 16'h0003, 0);
    check("guard_sp", sp, 16'hFFFD);
    check("guard_depth", depth, 2);
    check("guard_rsp_zero", last_rsp, 16'h0000);
    run_cmd(OP_POP, 16'h0000, 0);
    check("guard_pop_data", last_rsp, 16'h0002);
    run_cmd(OP_RET, 16'h0000, 0);
    check("guard_ret_sp", sp, 16'hFFFE);
    check("guard_ret_depth", depth, 1);
`endif

    run_cmd(OP_PUSH, 16'h00C3, 0);
    run_cmd(OP_POP, 16'h0000, 0);
    check("final_data", last_rsp, 16'h00C3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
